// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between instruction fetch and data requesters
// Define MEM_ARB_RR_EN for round-robin arbitration; default build gives D fixed priority over IF.
module mem_port_arbiter #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DWIDTH-1:0] d_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  output logic              busy_o
);
  generate
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
      $error("mem_port_arbiter: MEM_LAT must be 1..15");
    end
  endgenerate
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic owner_d, we_q, pick_d, gnt, done;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q, if_rdata_q, d_rdata_q;
`ifdef MEM_ARB_RR_EN
  logic last_d;
  assign pick_d = d_req_i && (!if_req_i || !last_d);
`else
  assign pick_d = d_req_i;
`endif
  always_comb begin
    d_gnt_o = state != ACCESS && pick_d;
    if_gnt_o = state != ACCESS && if_req_i && !pick_d;
    gnt = d_gnt_o || if_gnt_o;
    done = state == ACCESS && cnt == 4'(MEM_LAT - 1);
    state_nxt = gnt ? ACCESS : state == ACCESS ? (done ? RESP : ACCESS) : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      owner_d <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      if_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_d <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt <= (state == ACCESS && !done) ? cnt + 4'd1 : 4'd0;
      if (gnt) begin
        owner_d <= d_gnt_o;
        we_q <= d_gnt_o && d_we_i;
        addr_q <= d_gnt_o ? d_addr_i : if_addr_i;
        wdata_q <= d_gnt_o ? d_wdata_i : wdata_q;
`ifdef MEM_ARB_RR_EN
        last_d <= d_gnt_o;
`endif
      end
      if (done && !owner_d) if_rdata_q <= mem_rdata_i;
      if (done && owner_d) d_rdata_q <= we_q ? '0 : mem_rdata_i;
    end
  end
  assign mem_addr_o = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_read_en_o = state == ACCESS && !we_q;
  assign mem_write_en_o = state == ACCESS && we_q;
  assign if_rvalid_o = state == RESP && !owner_d;
  assign d_rvalid_o = state == RESP && owner_d;
  assign if_rdata_o = if_rdata_q;
  assign d_rdata_o = d_rdata_q;
  assign busy_o = state != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks on three arbiter instances with MEM_LAT = 1, 2, 3 sharing one stimulus
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic if_gnt [3], if_rvalid [3], d_gnt [3], d_rvalid [3], rd_en [3], wr_en [3], busy [3];
  logic [31:0] if_rdata [3], d_rdata [3], mem_addr [3], mem_wdata [3];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .MEM_LAT(g + 1)) u_dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt[g]), .if_rvalid_o(if_rvalid[g]), .if_rdata_o(if_rdata[g]),
      .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_gnt_o(d_gnt[g]), .d_rvalid_o(d_rvalid[g]), .d_rdata_o(d_rdata[g]),
      .mem_addr_o(mem_addr[g]), .mem_wdata_o(mem_wdata[g]), .mem_read_en_o(rd_en[g]), .mem_write_en_o(wr_en[g]),
      .mem_rdata_i(mem_rdata), .busy_o(busy[g])
    );
  end
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic test_reset();
    do_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (busy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got %b exp 0", k, busy[k]); end
      checks++; if ({rd_en[k], wr_en[k], if_rvalid[k], d_rvalid[k], if_gnt[k], d_gnt[k]} !== 6'b0) begin errors++; $display("FAIL reset_ctrl[%0d] got %b exp 0", k, {rd_en[k], wr_en[k], if_rvalid[k], d_rvalid[k], if_gnt[k], d_gnt[k]}); end
      checks++; if ({if_rdata[k], d_rdata[k], mem_addr[k], mem_wdata[k]} !== 128'b0) begin errors++; $display("FAIL reset_data[%0d] got %h exp 0", k, {if_rdata[k], d_rdata[k], mem_addr[k], mem_wdata[k]}); end
    end
  endtask
  task automatic test_reset_mid_access();
    do_reset();
    @(negedge clk); if_req = 1'b1; if_addr = 32'h0000_0040; mem_rdata = 32'h1234_5678; #1;
    checks++; if (if_gnt[2] !== 1'b1) begin errors++; $display("FAIL rma_gnt got %b exp 1", if_gnt[2]); end
    @(negedge clk); if_req = 1'b0;
    @(negedge clk); #1;
    checks++; if (rd_en[2] !== 1'b1 || busy[2] !== 1'b1) begin errors++; $display("FAIL rma_pre rd_en=%b busy=%b exp 1 1", rd_en[2], busy[2]); end
    rst = 1'b0; #1;
    checks++; if (rd_en[2] !== 1'b0 || busy[2] !== 1'b0) begin errors++; $display("FAIL rma_drop rd_en=%b busy=%b exp 0 0", rd_en[2], busy[2]); end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++; if (if_rvalid[2] !== 1'b0 || busy[2] !== 1'b0) begin errors++; $display("FAIL rma_norv cyc %0d rvalid=%b busy=%b exp 0 0", i, if_rvalid[2], busy[2]); end
    end
    @(negedge clk); if_req = 1'b1; #1;
    checks++; if (if_gnt[2] !== 1'b1) begin errors++; $display("FAIL rma_regrant got %b exp 1", if_gnt[2]); end
    @(negedge clk); if_req = 1'b0;
  endtask
  task automatic test_if_read();
    do_reset();
    @(negedge clk); if_req = 1'b1; if_addr = 32'h0100_0000; mem_rdata = 32'h0000_0093; #1;
    checks++; if (if_gnt[1] !== 1'b1 || d_gnt[1] !== 1'b0 || rd_en[1] !== 1'b0) begin errors++; $display("FAIL ifr_t0 gnt=%b dgnt=%b rd=%b exp 1 0 0", if_gnt[1], d_gnt[1], rd_en[1]); end
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk); if_req = 1'b0; #1;
      checks++; if (rd_en[1] !== 1'b1 || wr_en[1] !== 1'b0 || mem_addr[1] !== 32'h0100_0000 || if_rvalid[1] !== 1'b0) begin errors++; $display("FAIL ifr_t%0d rd=%b wr=%b addr=%h rv=%b exp 1 0 01000000 0", i, rd_en[1], wr_en[1], mem_addr[1], if_rvalid[1]); end
    end
    @(negedge clk); mem_rdata = 32'hFFFF_FFFF; #1;
    checks++; if (if_rvalid[1] !== 1'b1 || if_rdata[1] !== 32'h0000_0093 || rd_en[1] !== 1'b0) begin errors++; $display("FAIL ifr_t3 rv=%b rdata=%h rd=%b exp 1 00000093 0", if_rvalid[1], if_rdata[1], rd_en[1]); end
    @(negedge clk); #1;
    checks++; if (if_rvalid[1] !== 1'b0 || if_rdata[1] !== 32'h0000_0093 || busy[1] !== 1'b0 || mem_addr[1] !== 32'h0100_0000) begin errors++; $display("FAIL ifr_t4 rv=%b rdata=%h busy=%b addr=%h exp 0 00000093 0 01000000", if_rvalid[1], if_rdata[1], busy[1], mem_addr[1]); end
  endtask
  task automatic test_store();
    do_reset();
    @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0100_0400; d_wdata = 32'hDEAD_BEEF; mem_rdata = 32'h5555_5555; #1;
    checks++; if (d_gnt[0] !== 1'b1 || if_gnt[0] !== 1'b0) begin errors++; $display("FAIL st_t0 dgnt=%b ifgnt=%b exp 1 0", d_gnt[0], if_gnt[0]); end
    @(negedge clk); d_req = 1'b0; d_we = 1'b0; d_wdata = '0; #1;
    checks++; if (wr_en[0] !== 1'b1 || rd_en[0] !== 1'b0 || mem_addr[0] !== 32'h0100_0400 || mem_wdata[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_t1 wr=%b rd=%b addr=%h wdata=%h exp 1 0 01000400 deadbeef", wr_en[0], rd_en[0], mem_addr[0], mem_wdata[0]); end
    @(negedge clk); #1;
    checks++; if (d_rvalid[0] !== 1'b1 || d_rdata[0] !== 32'h0 || wr_en[0] !== 1'b0 || rd_en[0] !== 1'b0 || if_rvalid[0] !== 1'b0) begin errors++; $display("FAIL st_t2 rv=%b rdata=%h wr=%b rd=%b ifrv=%b exp 1 0 0 0 0", d_rvalid[0], d_rdata[0], wr_en[0], rd_en[0], if_rvalid[0]); end
    @(negedge clk); #1;
    checks++; if (d_rvalid[0] !== 1'b0 || busy[0] !== 1'b0 || mem_wdata[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_t3 rv=%b busy=%b wdata=%h exp 0 0 deadbeef", d_rvalid[0], busy[0], mem_wdata[0]); end
  endtask
  task automatic test_arbitration();
    logic exp_any, exp_d;
    do_reset();
    @(negedge clk); if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 32'h0000_1000; d_addr = 32'h0000_2000;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_any = (i % 2) == 0;
`ifdef MEM_ARB_RR_EN
      exp_d = exp_any && ((i / 2) % 2 == 0);
`else
      exp_d = exp_any;
`endif
      checks++; if (d_gnt[0] !== exp_d || if_gnt[0] !== (exp_any && !exp_d)) begin errors++; $display("FAIL arb cyc %0d dgnt=%b ifgnt=%b exp %b %b", i, d_gnt[0], if_gnt[0], exp_d, exp_any && !exp_d); end
    end
    @(negedge clk); if_req = 1'b0; d_req = 1'b0;
  endtask
  task automatic test_back_to_back();
    logic exp_g, exp_v;
    do_reset();
    @(negedge clk); if_addr = 32'h0000_0300;
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) @(negedge clk);
      if_req = i <= 4; mem_rdata = 32'h0000_1000 + 32'(i); #1;
      exp_g = (i % 2 == 0) && i <= 4;
      exp_v = (i % 2 == 0) && i >= 2;
      checks++; if (if_gnt[0] !== exp_g || if_rvalid[0] !== exp_v) begin errors++; $display("FAIL b2b cyc %0d gnt=%b rvalid=%b exp %b %b", i, if_gnt[0], if_rvalid[0], exp_g, exp_v); end
      if (exp_v) begin
        checks++; if (if_rdata[0] !== 32'h0000_1000 + 32'(i - 1)) begin errors++; $display("FAIL b2b_data cyc %0d got %h exp %h", i, if_rdata[0], 32'h0000_1000 + 32'(i - 1)); end
      end
    end
    @(negedge clk); #1;
    checks++; if (busy[0] !== 1'b0 || if_rvalid[0] !== 1'b0) begin errors++; $display("FAIL b2b_end busy=%b rvalid=%b exp 0 0", busy[0], if_rvalid[0]); end
  endtask
  initial begin
    test_reset();
    test_reset_mid_access();
    test_if_read();
    test_store();
    test_arbitration();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
